// File: rtl/digest_serializer.sv
// digest_serializer: splits one wide, byte-qualified hash digest into a
// multi-beat AXI-Stream packet on a narrower bus, low bytes first.
// One digest is held at a time; the input is only ready while idle.
module digest_serializer #(
  parameter int S_AXIS_DATA_WIDTH  = 512,
  parameter int M_AXIS_DATA_WIDTH  = 64,
  parameter int S_AXIS_TUSER_WIDTH = 128,
  parameter int M_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            reset,
  input  logic [S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast
);

  localparam int OB     = M_AXIS_DATA_WIDTH / 8;
  localparam int SB     = S_AXIS_DATA_WIDTH / 8;
  localparam int NB_MAX = S_AXIS_DATA_WIDTH / M_AXIS_DATA_WIDTH;
  localparam int LW     = $clog2(SB + 1);
  localparam int BW     = $clog2(NB_MAX) + 1;

  typedef enum logic [1:0] {IDLE, SEND, SKIP} state_t;

  state_t                         state, state_n;
  logic [S_AXIS_DATA_WIDTH-1:0]   digest_q, digest_n;
  logic [S_AXIS_DATA_WIDTH-1:0]   din_masked;
  logic [LW-1:0]                  len_q, len_n, len_in;
  logic [BW-1:0]                  beat_q, beat_n;
  logic                           s_tready_n, m_tvalid_n, m_tlast_n;
  logic [M_AXIS_DATA_WIDTH-1:0]   m_tdata_n;
  logic [OB-1:0]                  m_tkeep_n;
  logic [M_AXIS_TUSER_WIDTH-1:0]  m_tuser_n;

  // Every accepted beat is a whole digest, so tlast carries no information.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  // Keep mask of beat k for a digest of len bytes.
  function automatic logic [OB-1:0] beat_keep(input logic [BW-1:0] k, input logic [LW-1:0] len);
    logic [OB-1:0] kp;
    for (int i = 0; i < OB; i++) kp[i] = (int'(k) * OB + i) < int'(len);
    return kp;
  endfunction

  // Beat k is last once it covers the final valid byte.
  function automatic logic beat_last(input logic [BW-1:0] k, input logic [LW-1:0] len);
    return ((int'(k) + 1) * OB) >= int'(len);
  endfunction

  // Digest length is the keep popcount; a gappy keep only affects the count.
  always_comb begin
    len_in = '0;
    for (int i = 0; i < SB; i++) len_in = len_in + LW'(s_axis_tkeep[i]);
  end

  // Zero bytes past len at capture so beats never leak stale upper bytes.
  always_comb begin
    din_masked = '0;
    for (int i = 0; i < SB; i++)
      din_masked[i*8 +: 8] = (i < int'(len_in)) ? s_axis_tdata[i*8 +: 8] : 8'h00;
  end

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_n    = state;
    digest_n   = digest_q;
    len_n      = len_q;
    beat_n     = beat_q;
    s_tready_n = s_axis_tready;
    m_tvalid_n = m_axis_tvalid;
    m_tlast_n  = m_axis_tlast;
    m_tdata_n  = m_axis_tdata;
    m_tkeep_n  = m_axis_tkeep;
    m_tuser_n  = m_axis_tuser;
    case (state)
      IDLE: begin
        if (s_axis_tvalid) begin
          digest_n   = din_masked;
          len_n      = len_in;
          beat_n     = '0;
          s_tready_n = 1'b0;
          if (len_in == '0) begin
            // Empty digest: burn one cycle so ready returns two edges later.
            state_n = SKIP;
          end else begin
            state_n    = SEND;
            m_tvalid_n = 1'b1;
            m_tdata_n  = din_masked[M_AXIS_DATA_WIDTH-1:0];
            m_tkeep_n  = beat_keep('0, len_in);
            m_tlast_n  = beat_last('0, len_in);
            m_tuser_n  = s_axis_tuser;
          end
        end
      end
      SEND: begin
        if (m_axis_tready) begin
          if (m_axis_tlast) begin
            state_n    = IDLE;
            m_tvalid_n = 1'b0;
            m_tlast_n  = 1'b0;
            s_tready_n = 1'b1;
          end else begin
            beat_n    = beat_q + 1'b1;
            m_tdata_n = digest_q[int'(beat_n) * M_AXIS_DATA_WIDTH +: M_AXIS_DATA_WIDTH];
            m_tkeep_n = beat_keep(beat_n, len_q);
            m_tlast_n = beat_last(beat_n, len_q);
          end
        end
      end
      SKIP: begin
        state_n    = IDLE;
        s_tready_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any digest in flight.
  always_ff @(posedge axi_aclk) begin
    if (reset) begin
      state         <= IDLE;
      digest_q      <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      s_axis_tready <= 1'b1;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else begin
      state         <= state_n;
      digest_q      <= digest_n;
      len_q         <= len_n;
      beat_q        <= beat_n;
      s_axis_tready <= s_tready_n;
      m_axis_tvalid <= m_tvalid_n;
      m_axis_tlast  <= m_tlast_n;
      m_axis_tdata  <= m_tdata_n;
      m_axis_tkeep  <= m_tkeep_n;
      m_axis_tuser  <= m_tuser_n;
    end
  end

`ifndef SYNTHESIS
  // Upstream must present keep as a contiguous run starting at byte 0.
  keep_contiguous: assert property (@(posedge axi_aclk) disable iff (reset)
    (s_axis_tvalid && s_axis_tready) |-> ((s_axis_tkeep & (s_axis_tkeep + SB'(1))) == '0));
`endif

endmodule

// File: tb/tb_digest_serializer.sv
// tb_digest_serializer: randomized digests checked against a byte-level
// model of the expected output packet.
module tb_digest_serializer;
  localparam int SW = 512, MW = 64, UW = 128, OB = 8;

  logic            axi_aclk = 1'b0;
  logic            reset;
  logic [SW-1:0]   s_axis_tdata;
  logic [SW/8-1:0] s_axis_tkeep;
  logic [UW-1:0]   s_axis_tuser;
  logic            s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [MW-1:0]   m_axis_tdata;
  logic [OB-1:0]   m_axis_tkeep;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;

  always #5 axi_aclk = ~axi_aclk;

  digest_serializer dut (
    .axi_aclk(axi_aclk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast)
  );

  int n_tests = 0, n_fail = 0;

  // Expected packet for the digest currently in flight.
  logic [MW-1:0] exp_data[$];
  logic [OB-1:0] exp_keep[$];
  logic          exp_last[$];
  logic [UW-1:0] exp_user;

  function automatic logic [SW-1:0] rand_data();
    logic [SW-1:0] r;
    for (int i = 0; i < SW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [UW-1:0] r;
    for (int i = 0; i < UW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [SW/8-1:0] keep_of(input int len);
    logic [SW/8-1:0] k;
    for (int i = 0; i < SW/8; i++) k[i] = (i < len);
    return k;
  endfunction

  // Cut the first len bytes into OB-byte beats, zero-padding the last one.
  task automatic model(input logic [SW-1:0] d, input int len, input logic [UW-1:0] u);
    int nb;
    exp_data.delete(); exp_keep.delete(); exp_last.delete();
    exp_user = u;
    nb = (len + OB - 1) / OB;
    for (int k = 0; k < nb; k++) begin
      logic [MW-1:0] bd;
      logic [OB-1:0] bk;
      bd = '0; bk = '0;
      for (int i = 0; i < OB; i++)
        if (k*OB + i < len) begin
          bd[i*8 +: 8] = d[(k*OB + i)*8 +: 8];
          bk[i] = 1'b1;
        end
      exp_data.push_back(bd);
      exp_keep.push_back(bk);
      exp_last.push_back(k == nb - 1);
    end
  endtask

  // Offer one digest; returns at the negedge after the accepting edge.
  task automatic present(input logic [SW-1:0] d, input int len, input logic [UW-1:0] u, input bit hold);
    int c = 0;
    while (s_axis_tready !== 1'b1 && c < 50) begin @(negedge axi_aclk); c++; end
    n_tests++;
    if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL present_ready got %b want 1", s_axis_tready); end
    model(d, len, u);
    s_axis_tdata = d; s_axis_tkeep = keep_of(len); s_axis_tuser = u; s_axis_tvalid = 1'b1;
    @(negedge axi_aclk);
    if (!hold) s_axis_tvalid = 1'b0;
    n_tests++;
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL accept_drops_ready got %b want 0", s_axis_tready); end
  endtask

  // Drain the packet with a ready pattern: 0 always, 1 toggling 1,0,0,1, 2 random.
  task automatic collect(input int mode, input string name);
    int idx = 0, c = 0;
    bit done = 0, stalled = 0, rdy;
    logic [MW+OB+UW:0] cur, snap, want;
    while (!done && c < 200) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
      m_axis_tready = rdy;
      cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      n_tests++;
      if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL %s valid_beat%0d got %b want 1", name, idx, m_axis_tvalid); end
      if (stalled) begin
        n_tests++;
        if (cur !== snap) begin n_fail++; $display("FAIL %s stall_hold beat%0d got %h want %h", name, idx, cur, snap); end
      end
      if (rdy) begin
        stalled = 0;
        n_tests++;
        if (idx < exp_data.size()) begin
          want = {exp_data[idx], exp_keep[idx], exp_last[idx], exp_user};
          if (cur !== want) begin n_fail++; $display("FAIL %s beat%0d got %h want %h", name, idx, cur, want); end
          if (exp_last[idx]) done = 1;
        end else begin
          n_fail++; $display("FAIL %s extra_beat%0d got %h want none", name, idx, cur);
          done = 1;
        end
        idx++;
      end else begin
        stalled = 1; snap = cur;
      end
      @(negedge axi_aclk);
      c++;
    end
    m_axis_tready = 1'b1;
    n_tests++;
    if (!done) begin n_fail++; $display("FAIL %s timeout beats got %0d want %0d", name, idx, exp_data.size()); end
    n_tests++;
    if (idx != exp_data.size()) begin n_fail++; $display("FAIL %s beat_count got %0d want %0d", name, idx, exp_data.size()); end
    n_tests++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready} !== 3'b001) begin
      n_fail++; $display("FAIL %s post_packet v/l/rdy got %b want 001", name, {m_axis_tvalid, m_axis_tlast, s_axis_tready});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b1; m_axis_tready = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    repeat (3) @(negedge axi_aclk);
    reset = 1'b0;
    repeat (3) @(negedge axi_aclk);
    n_tests++;
    if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL reset_s_tready got %b want 1", s_axis_tready); end
    n_tests++;
    if ({m_axis_tvalid, m_axis_tlast} !== 2'b00) begin n_fail++; $display("FAIL reset_valid_last got %b want 00", {m_axis_tvalid, m_axis_tlast}); end
    n_tests++;
    if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    n_tests++;
    if (m_axis_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep got %h want 0", m_axis_tkeep); end
  endtask

  task automatic test_sha256();
    logic [SW-1:0] d = rand_data();
    for (int i = 0; i < 32; i++) d[i*8 +: 8] = 8'(i);
    present(d, 32, rand_user(), 0);
    n_tests++;
    if (m_axis_tdata !== 64'h0706050403020100) begin n_fail++; $display("FAIL sha256_beat0 got %h want 0706050403020100", m_axis_tdata); end
    collect(0, "sha256");
  endtask

  task automatic test_sha224();
    present(rand_data(), 28, rand_user(), 0);
    collect(0, "sha224");
  endtask

  task automatic test_sha512_stall();
    present(rand_data(), 64, rand_user(), 0);
    collect(1, "sha512_stall");
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] d2 = rand_data();
    logic [UW-1:0] u2 = rand_user();
    present(rand_data(), 48, rand_user(), 1);
    s_axis_tdata = d2; s_axis_tkeep = keep_of(48); s_axis_tuser = u2;
    collect(0, "b2b_first");
    present(d2, 48, u2, 0);
    collect(0, "b2b_second");
  endtask

  task automatic test_reset_mid_packet();
    logic [SW-1:0] d = rand_data();
    present(d, 64, rand_user(), 0);
    m_axis_tready = 1'b1;
    repeat (2) @(negedge axi_aclk);
    n_tests++;
    if (m_axis_tdata !== d[2*MW +: MW]) begin n_fail++; $display("FAIL midrst_beat2 got %h want %h", m_axis_tdata, d[2*MW +: MW]); end
    reset = 1'b1;
    @(negedge axi_aclk);
    reset = 1'b0;
    n_tests++;
    if ({m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tkeep} !== {1'b0, 1'b1, 64'h0, 8'h0}) begin
      n_fail++; $display("FAIL midrst_state v/rdy got %b%b data %h keep %h want 01 0 0", m_axis_tvalid, s_axis_tready, m_axis_tdata, m_axis_tkeep);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge axi_aclk);
      n_tests++;
      if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_quiet%0d got %b want 0", i, m_axis_tvalid); end
    end
    present(rand_data(), 32, rand_user(), 0);
    collect(0, "midrst_sha256");
  endtask

  task automatic test_empty();
    present(rand_data(), 0, rand_user(), 0);
    n_tests++;
    if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL empty_no_beat got %b want 0", m_axis_tvalid); end
    @(negedge axi_aclk);
    n_tests++;
    if ({m_axis_tvalid, s_axis_tready} !== 2'b01) begin n_fail++; $display("FAIL empty_ready_back v/rdy got %b want 01", {m_axis_tvalid, s_axis_tready}); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 12; p++) begin
      int len = $urandom_range(0, 64);
      present(rand_data(), len, rand_user(), 0);
      if (len == 0) begin
        @(negedge axi_aclk);
        n_tests++;
        if ({m_axis_tvalid, s_axis_tready} !== 2'b01) begin n_fail++; $display("FAIL rand%0d_empty v/rdy got %b want 01", p, {m_axis_tvalid, s_axis_tready}); end
      end else begin
        collect(2, $sformatf("rand%0d_len%0d", p, len));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sha256();
    test_sha224();
    test_sha512_stall();
    test_back_to_back();
    test_reset_mid_packet();
    test_empty();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
